// File: rtl/lsu.sv
// Load/store unit: bridges the single-cycle datapath to a variable-latency
// data bus with req/ready/rvalid handshake, stall, extension and error flags.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   MemRead, MemWrite, funct3  access request from the datapath
//   ALUResult, WriteData       byte address and store data
//   ReadData                   extended load result (held between loads)
//   Stall                      core must hold PC / writeback
//   AccessErr                  illegal/misaligned (comb) or timeout (in DONE)
//   mem_req, mem_we, mem_addr  bus request, direction, word address
//   mem_be, mem_wdata          byte enables, lane-replicated store data
//   mem_ready, mem_rvalid      bus accept and read-data-valid
//   mem_rdata                  bus read data word
module lsu #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          err_q;

  logic          ld_ok;
  logic          st_ok;
  logic          align_ok;
  logic          legal;
  logic          launch;
  logic          illegal;
  logic          timeout;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [31:0]   lane;
  logic [31:0]   ext;

  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        ld_ok = 1'b1;
        st_ok = 1'b1;
      end
      3'b100, 3'b101: ld_ok = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   align_ok = ~ALUResult[0];
      2'b10:   align_ok = (ALUResult[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
  end

  assign legal   = (MemRead ^ MemWrite)
                 & (MemRead ? ld_ok : st_ok)
                 & align_ok;
  assign launch  = (state == S_IDLE) & legal;
  assign illegal = (state == S_IDLE) & (MemRead | MemWrite) & ~legal;

  // >= so a handshake on the last counted cycle cannot skip the limit
  assign timeout = ((state == S_REQ) | (state == S_WAIT))
                 & (cnt >= CNT_LAST);

  assign Stall     = launch | (state == S_REQ) | (state == S_WAIT);
  assign AccessErr = illegal | ((state == S_DONE) & err_q);
  assign mem_req   = (state == S_REQ);

  always_comb begin
    be_n = 4'b1111;
    wd_n = 32'h0;
    if (MemWrite) begin
      case (funct3[1:0])
        2'b00: begin
          be_n = 4'b0001 << ALUResult[1:0];
          wd_n = {4{WriteData[7:0]}};
        end
        2'b01: begin
          be_n = ALUResult[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{WriteData[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = WriteData;
        end
      endcase
    end
  end

  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'h0, lane[7:0]};
      3'b101:  ext = {16'h0, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      err_q     <= 1'b0;
      ReadData  <= 32'h0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (launch) begin
            cnt       <= '0;
            f3_q      <= funct3;
            off_q     <= ALUResult[1:0];
            mem_we    <= MemWrite;
            mem_addr  <= {ALUResult[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wd_n;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_ready) begin
            state <= mem_we ? S_DONE : S_WAIT;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            ReadData <= ext;
            state    <= S_DONE;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          err_q <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed testbench for lsu: stores, loads, stalls, errors, timeout, reset.
// Inputs change 2 units after the rising edge; outputs sampled 1 unit later.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        AccessErr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errs    = 0;

  lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Stall      (Stall),
    .AccessErr  (AccessErr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'b000;
    ALUResult = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_rd"},    ReadData, 32'h0);
    chk({tag, "_stall"}, {31'h0, Stall}, 32'h0);
    chk({tag, "_err"},   {31'h0, AccessErr}, 32'h0);
    chk({tag, "_req"},   {31'h0, mem_req}, 32'h0);
    chk({tag, "_we"},    {31'h0, mem_we}, 32'h0);
    chk({tag, "_addr"},  mem_addr, 32'h0);
    chk({tag, "_be"},    {28'h0, mem_be}, 32'h0);
    chk({tag, "_wd"},    mem_wdata, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    idle_in();
    #3;
    all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // SW, zero-wait bus
    MemWrite = 1'b1; funct3 = 3'b010;
    ALUResult = 32'h100; WriteData = 32'hDEADBEEF;
    mem_ready = 1'b1;
    #1;
    chk("sw_c0_stall", {31'h0, Stall}, 32'h1);
    chk("sw_c0_req", {31'h0, mem_req}, 32'h0);
    tick(); #1;
    chk("sw_c1_req", {31'h0, mem_req}, 32'h1);
    chk("sw_c1_we", {31'h0, mem_we}, 32'h1);
    chk("sw_c1_be", {28'h0, mem_be}, 32'hF);
    chk("sw_c1_addr", mem_addr, 32'h100);
    chk("sw_c1_wd", mem_wdata, 32'hDEADBEEF);
    chk("sw_c1_stall", {31'h0, Stall}, 32'h1);
    tick(); #1;
    chk("sw_done_stall", {31'h0, Stall}, 32'h0);
    chk("sw_done_req", {31'h0, mem_req}, 32'h0);
    chk("sw_done_err", {31'h0, AccessErr}, 32'h0);
    tick();
    idle_in(); mem_ready = 1'b0;
    #1;
    chk("sw_idle_stall", {31'h0, Stall}, 32'h0);

    // LB then LBU at 0x203, rvalid two cycles after handshake
    for (int k = 0; k < 2; k++) begin
      MemRead = 1'b1; funct3 = (k == 0) ? 3'b000 : 3'b100;
      ALUResult = 32'h203; mem_ready = 1'b1;
      #1;
      chk("ld_c0_stall", {31'h0, Stall}, 32'h1);
      tick(); #1;
      chk("ld_c1_req", {31'h0, mem_req}, 32'h1);
      chk("ld_c1_we", {31'h0, mem_we}, 32'h0);
      chk("ld_c1_be", {28'h0, mem_be}, 32'hF);
      chk("ld_c1_addr", mem_addr, 32'h200);
      chk("ld_c1_stall", {31'h0, Stall}, 32'h1);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("ld_c2_stall", {31'h0, Stall}, 32'h1);
      chk("ld_c2_req", {31'h0, mem_req}, 32'h0);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF0000;
      #1;
      chk("ld_c3_stall", {31'h0, Stall}, 32'h1);
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      #1;
      chk("ld_done_stall", {31'h0, Stall}, 32'h0);
      chk(k == 0 ? "lb_data" : "lbu_data", ReadData,
          k == 0 ? 32'hFFFFFF80 : 32'h00000080);
      tick();
      idle_in();
    end

    // SH with bus stalled for 3 cycles
    MemWrite = 1'b1; funct3 = 3'b001;
    ALUResult = 32'h6; WriteData = 32'h1234ABCD;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_req", {31'h0, mem_req}, 32'h1);
      chk("sh_be", {28'h0, mem_be}, 32'hC);
      chk("sh_wd", mem_wdata, 32'hABCDABCD);
      chk("sh_addr", mem_addr, 32'h4);
      chk("sh_we", {31'h0, mem_we}, 32'h1);
      chk("sh_stall", {31'h0, Stall}, 32'h1);
      tick();
    end
    mem_ready = 1'b1;
    tick(); #1;
    chk("sh_done_stall", {31'h0, Stall}, 32'h0);
    tick();
    idle_in(); mem_ready = 1'b0;

    // SB lane 2
    MemWrite = 1'b1; funct3 = 3'b000;
    ALUResult = 32'h22; WriteData = 32'h000000A5;
    mem_ready = 1'b1;
    tick(); #1;
    chk("sb_be", {28'h0, mem_be}, 32'h4);
    chk("sb_wd", mem_wdata, 32'hA5A5A5A5);
    tick(); tick();
    idle_in(); mem_ready = 1'b0;

    // Misaligned LW
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h102;
    #1;
    chk("mis_err", {31'h0, AccessErr}, 32'h1);
    chk("mis_stall", {31'h0, Stall}, 32'h0);
    chk("mis_req", {31'h0, mem_req}, 32'h0);
    tick();
    idle_in();
    #1;
    chk("mis_err_clr", {31'h0, AccessErr}, 32'h0);
    chk("mis_req_after", {31'h0, mem_req}, 32'h0);

    // Illegal store size and both strobes
    MemWrite = 1'b1; funct3 = 3'b100; ALUResult = 32'h40;
    #1;
    chk("st_f3_err", {31'h0, AccessErr}, 32'h1);
    chk("st_f3_stall", {31'h0, Stall}, 32'h0);
    MemRead = 1'b1; funct3 = 3'b010;
    #1;
    chk("both_err", {31'h0, AccessErr}, 32'h1);
    tick();
    idle_in();

    // Timeout with ready held low
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h300;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_req", {31'h0, mem_req}, 32'h1);
      chk("to_err_low", {31'h0, AccessErr}, 32'h0);
      tick();
    end
    #1;
    chk("to_err", {31'h0, AccessErr}, 32'h1);
    chk("to_req_drop", {31'h0, mem_req}, 32'h0);
    chk("to_stall", {31'h0, Stall}, 32'h0);
    chk("to_rd_keep", ReadData, 32'h00000080);
    tick();
    idle_in();
    #1;
    chk("to_err_clr", {31'h0, AccessErr}, 32'h0);

    // Reset mid-WAIT then late rvalid
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h400;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick(); #1;
    chk("rw_wait_stall", {31'h0, Stall}, 32'h1);
    rst_n = 1'b0;
    idle_in();
    #1;
    all_zero("rw_rst");
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    tick();
    rst_n = 1'b1;
    tick(); #1;
    all_zero("rw_late");
    mem_rvalid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
